// File: rtl/digest_cmp_pkg.sv
// Shared encodings for the streamed digest comparator: compare modes, FSM
// states and the mode -> verdict mapping applied once all words are seen.
package digest_cmp_pkg;

    typedef enum logic [1:0] {
        MODE_EQ = 2'b00,
        MODE_NE = 2'b01,
        MODE_LT = 2'b10,
        MODE_LE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_e;

    function automatic logic verdict(input mode_e m, input logic eq, input logic lt);
        case (m)
            MODE_EQ: return eq;
            MODE_NE: return ~eq;
            MODE_LT: return lt & ~eq;
            default: return lt | eq;
        endcase
    endfunction

endpackage

// File: rtl/digest_cmp_seq_if.sv
// Word-stream bus between the hash core (master) and the digest comparator (slave).
interface digest_cmp_seq_if #(
    parameter int N = 32
);
    logic         Start;
    logic [1:0]   Mode;
    logic         Valid;
    logic [N-1:0] DataIn0;
    logic [N-1:0] DataIn1;
    logic         Ready;
    logic         Done;
    logic         Op;
    logic         Busy;

    modport master (
        output Start, Mode, Valid, DataIn0, DataIn1,
        input  Ready, Done, Op, Busy
    );

    modport slave (
        input  Start, Mode, Valid, DataIn0, DataIn1,
        output Ready, Done, Op, Busy
    );
endinterface

// File: rtl/digest_cmp_seq_cmp_word.sv
// Single N-bit unsigned word compare; one instance serves every beat.
module cmp_word #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_eq,
    output logic         o_lt
);
    assign o_eq = (i_a == i_b);
    assign o_lt = (i_a < i_b);
endmodule

// File: rtl/digest_cmp_seq.sv
// Multi-word MSW-first comparator: streams WORDS beats, latches the first
// differing word's ordering and reports an EQ/NE/LT/LE verdict with a Done pulse.
module digest_cmp_seq
    import digest_cmp_pkg::*;
#(
    parameter  int N     = 32,
    parameter  int WORDS = 8,
    localparam int CW    = $clog2(WORDS + 1)
) (
    input logic              Clk,
    input logic              Rst_n,
    digest_cmp_seq_if.slave  bus
);
    localparam logic [CW-1:0] LAST = CW'(WORDS);

    state_e        r_state;
    mode_e         r_mode;
    logic [CW-1:0] r_cnt;
    logic          r_eq, r_lt, r_dec;
    logic          r_ready, r_done, r_op, r_busy;

    logic          w_weq, w_wlt;
    logic          w_restart, w_hit, w_last;
    mode_e         w_mode;
    logic [CW-1:0] w_b_cnt, w_n_cnt;
    logic          w_b_eq, w_b_lt, w_b_dec;
    logic          w_n_eq, w_n_lt, w_n_dec;

    cmp_word #(.N(N)) u_cmp (
        .i_a  (bus.DataIn0),
        .i_b  (bus.DataIn1),
        .o_eq (w_weq),
        .o_lt (w_wlt)
    );

    // Start during RUN restarts: the same-cycle word accumulates onto fresh
    // init values rather than onto the aborted comparison's state.
    assign w_restart = (r_state == RUN) && bus.Start;
    assign w_mode    = w_restart ? mode_e'(bus.Mode) : r_mode;
    assign w_b_cnt   = w_restart ? '0 : r_cnt;
    assign w_b_eq    = w_restart | r_eq;
    assign w_b_lt    = ~w_restart & r_lt;
    assign w_b_dec   = ~w_restart & r_dec;

    assign w_hit     = ~w_b_dec & ~w_weq;
    assign w_n_eq    = w_b_eq & ~w_hit;
    assign w_n_dec   = w_b_dec | w_hit;
    assign w_n_lt    = w_hit ? w_wlt : w_b_lt;
    assign w_n_cnt   = w_b_cnt + 1'b1;
    assign w_last    = bus.Valid && (w_n_cnt == LAST);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= IDLE;
            r_mode  <= MODE_EQ;
            r_cnt   <= '0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_dec   <= 1'b0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_op    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, FIN: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    if (bus.Start) begin
                        r_state <= RUN;
                        r_mode  <= mode_e'(bus.Mode);
                        r_cnt   <= '0;
                        r_eq    <= 1'b1;
                        r_lt    <= 1'b0;
                        r_dec   <= 1'b0;
                        r_op    <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    r_mode <= w_mode;
                    r_cnt  <= bus.Valid ? w_n_cnt : w_b_cnt;
                    r_eq   <= bus.Valid ? w_n_eq  : w_b_eq;
                    r_lt   <= bus.Valid ? w_n_lt  : w_b_lt;
                    r_dec  <= bus.Valid ? w_n_dec : w_b_dec;
                    if (w_restart)
                        r_op <= 1'b0;
                    if (w_last) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                        r_op    <= verdict(w_mode, w_n_eq, w_n_lt);
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Ready = r_ready;
    assign bus.Done  = r_done;
    assign bus.Op    = r_op;
    assign bus.Busy  = r_busy;

endmodule

// File: tb/tb_digest_cmp_seq.sv
// Directed bench for digest_cmp_seq (N=32, WORDS=8): modes, latency, Valid
// gaps, restart, mid-run reset and back-to-back comparisons.
module tb_digest_cmp_seq;
    import digest_cmp_pkg::*;

    localparam int N     = 32;
    localparam int WORDS = 8;
    typedef logic [WORDS-1:0][N-1:0] wvec_t;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    digest_cmp_seq_if #(.N(N)) bus ();

    digest_cmp_seq #(.N(N), .WORDS(WORDS)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk)
        if (bus.Done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Issues Start, streams a then b MSW first, returns cycles from Start to Done.
    task automatic do_cmp(input logic [1:0] m, input wvec_t a, input wvec_t b,
                          input bit toggle, output int lat, output logic op,
                          output logic busy0, output logic op0);
        int k;
        k   = 0;
        lat = -1;
        op  = 1'bx;
        bus.Start = 1'b1; bus.Mode = m; bus.Valid = 1'b0;
        tick;
        busy0 = bus.Busy;
        op0   = bus.Op;
        bus.Start = 1'b0; bus.Mode = ~m;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            bus.Valid = (k < WORDS) && (!toggle || (cyc % 2 == 1));
            if (bus.Valid) begin
                bus.DataIn0 = a[k]; bus.DataIn1 = b[k];
            end else begin
                bus.DataIn0 = '1;   bus.DataIn1 = '0;
            end
            tick;
            if (bus.Valid) k++;
            if (bus.Done === 1'b1) begin
                lat = cyc + 1;
                op  = bus.Op;
                break;
            end
        end
        bus.Valid = 1'b0;
    endtask

    task automatic test_reset;
        bus.Start = 0; bus.Mode = 0; bus.Valid = 0; bus.DataIn0 = 0; bus.DataIn1 = 0;
        Rst_n = 1'b0;
        tick; tick;
        n_chk++; if (bus.Ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.Ready); end
        n_chk++; if (bus.Done  !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.Done); end
        n_chk++; if (bus.Op    !== 1'b0) begin n_fail++; $display("FAIL rst_op: got %b want 0", bus.Op); end
        n_chk++; if (bus.Busy  !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.Busy); end
        Rst_n = 1'b1;
        tick;
        n_chk++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", bus.Busy); end
    endtask

    task automatic test_eq;
        wvec_t a, b;
        int lat; logic op, b0, o0;
        for (int i = 0; i < WORDS; i++) begin a[i] = N'(i); b[i] = N'(i); end
        do_cmp(MODE_EQ, a, b, 1'b0, lat, op, b0, o0);
        n_chk++; if (b0  !== 1'b1) begin n_fail++; $display("FAIL eq_busy: got %b want 1", b0); end
        n_chk++; if (lat !== 9)    begin n_fail++; $display("FAIL eq_lat: got %0d want 9", lat); end
        n_chk++; if (op  !== 1'b1) begin n_fail++; $display("FAIL eq_op: got %b want 1", op); end
        tick;
        n_chk++; if (bus.Op !== 1'b1) begin n_fail++; $display("FAIL eq_hold: got %b want 1", bus.Op); end
        b[7] = 32'hDEAD_0007;
        do_cmp(MODE_EQ, a, b, 1'b0, lat, op, b0, o0);
        n_chk++; if (o0  !== 1'b0) begin n_fail++; $display("FAIL eq_opclr: got %b want 0", o0); end
        n_chk++; if (op  !== 1'b0) begin n_fail++; $display("FAIL eq_diff_op: got %b want 0", op); end
        tick;
        n_chk++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL eq_done_pulse: got %b want 0", bus.Done); end
    endtask

    task automatic test_lt_msw;
        wvec_t a, b;
        int lat; logic op, b0, o0;
        for (int i = 0; i < WORDS; i++) begin a[i] = '1; b[i] = '0; end
        a[0] = 32'd1; b[0] = 32'd2;
        do_cmp(MODE_LT, a, b, 1'b0, lat, op, b0, o0); tick;
        n_chk++; if (op !== 1'b1) begin n_fail++; $display("FAIL lt_msw: got %b want 1", op); end
        do_cmp(MODE_LE, a, b, 1'b0, lat, op, b0, o0); tick;
        n_chk++; if (op !== 1'b1) begin n_fail++; $display("FAIL le_msw: got %b want 1", op); end
        a[0] = 32'd2; b[0] = 32'd1;
        do_cmp(MODE_LT, a, b, 1'b0, lat, op, b0, o0); tick;
        n_chk++; if (op !== 1'b0) begin n_fail++; $display("FAIL lt_gt: got %b want 0", op); end
        do_cmp(MODE_NE, a, b, 1'b0, lat, op, b0, o0); tick;
        n_chk++; if (op !== 1'b1) begin n_fail++; $display("FAIL ne_gt: got %b want 1", op); end
    endtask

    task automatic test_equal_modes;
        wvec_t a;
        int lat; logic op, b0, o0;
        for (int i = 0; i < WORDS; i++) a[i] = 32'hA5A5_0000 + N'(i);
        do_cmp(MODE_LE, a, a, 1'b0, lat, op, b0, o0); tick;
        n_chk++; if (op !== 1'b1) begin n_fail++; $display("FAIL le_eq: got %b want 1", op); end
        do_cmp(MODE_LT, a, a, 1'b0, lat, op, b0, o0); tick;
        n_chk++; if (op !== 1'b0) begin n_fail++; $display("FAIL lt_eq: got %b want 0", op); end
        do_cmp(MODE_NE, a, a, 1'b0, lat, op, b0, o0); tick;
        n_chk++; if (op !== 1'b0) begin n_fail++; $display("FAIL ne_eq: got %b want 0", op); end
    endtask

    task automatic test_valid_toggle;
        wvec_t a;
        int lat, d0; logic op, b0, o0;
        for (int i = 0; i < WORDS; i++) a[i] = 32'h1000_0000 + N'(i);
        d0 = done_cnt;
        do_cmp(MODE_EQ, a, a, 1'b1, lat, op, b0, o0);
        n_chk++; if (lat !== 16)   begin n_fail++; $display("FAIL tog_lat: got %0d want 16", lat); end
        n_chk++; if (op  !== 1'b1) begin n_fail++; $display("FAIL tog_op: got %b want 1", op); end
        tick;
        d0 = done_cnt - d0;
        n_chk++; if (d0 !== 1) begin n_fail++; $display("FAIL tog_done_cnt: got %0d want 1", d0); end
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            bus.Valid = (i % 2 == 0); bus.DataIn0 = 32'h1; bus.DataIn1 = 32'h2;
            tick;
        end
        bus.Valid = 1'b0;
        tick;
        n_chk++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL idle_valid_busy: got %b want 0", bus.Busy); end
        n_chk++; if (bus.Op !== 1'b1)   begin n_fail++; $display("FAIL idle_valid_op: got %b want 1", bus.Op); end
        n_chk++; if (done_cnt !== d0)   begin n_fail++; $display("FAIL idle_valid_done: got %0d want %0d", done_cnt, d0); end
    endtask

    task automatic test_restart;
        int d0; bit early;
        early = 0;
        bus.Start = 1; bus.Mode = MODE_EQ; bus.Valid = 0;
        tick;
        bus.Start = 0;
        for (int i = 0; i < 3; i++) begin
            bus.Valid = 1; bus.DataIn0 = 32'd5; bus.DataIn1 = 32'd6;
            tick;
        end
        d0 = done_cnt;
        bus.Start = 1; bus.Mode = MODE_LT; bus.DataIn0 = 32'd1; bus.DataIn1 = 32'd2;
        tick;
        bus.Start = 0; bus.Mode = MODE_EQ;
        n_chk++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL rs_busy: got %b want 1", bus.Busy); end
        bus.DataIn0 = '1; bus.DataIn1 = '0;
        for (int i = 0; i < 7; i++) begin
            tick;
            if (i < 6 && bus.Done !== 1'b0) early = 1;
        end
        n_chk++; if (early !== 1'b0)    begin n_fail++; $display("FAIL rs_early_done: got %b want 0", early); end
        n_chk++; if (bus.Done !== 1'b1) begin n_fail++; $display("FAIL rs_done: got %b want 1", bus.Done); end
        n_chk++; if (bus.Op !== 1'b1)   begin n_fail++; $display("FAIL rs_op: got %b want 1", bus.Op); end
        bus.Valid = 0;
        tick; tick;
        d0 = done_cnt - d0;
        n_chk++; if (d0 !== 1) begin n_fail++; $display("FAIL rs_done_cnt: got %0d want 1", d0); end
    endtask

    task automatic test_reset_mid;
        wvec_t a, b;
        int lat, d0; logic op, b0, o0;
        bus.Start = 1; bus.Mode = MODE_NE; bus.Valid = 0;
        tick;
        bus.Start = 0;
        for (int i = 0; i < 3; i++) begin
            bus.Valid = 1; bus.DataIn0 = 32'd7; bus.DataIn1 = 32'd9;
            tick;
        end
        bus.Valid = 0; Rst_n = 0;
        tick;
        Rst_n = 1;
        n_chk++; if (bus.Busy !== 1'b0)  begin n_fail++; $display("FAIL rm_busy: got %b want 0", bus.Busy); end
        n_chk++; if (bus.Op !== 1'b0)    begin n_fail++; $display("FAIL rm_op: got %b want 0", bus.Op); end
        n_chk++; if (bus.Ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready: got %b want 0", bus.Ready); end
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin bus.Valid = 1; tick; end
        bus.Valid = 0;
        tick;
        n_chk++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rm_no_done: got %0d want %0d", done_cnt, d0); end
        for (int i = 0; i < WORDS; i++) begin a[i] = 32'h0F0F_0000 + N'(i); b[i] = a[i]; end
        b[3] = 32'h0;
        do_cmp(MODE_NE, a, b, 1'b0, lat, op, b0, o0);
        n_chk++; if (lat !== 9)    begin n_fail++; $display("FAIL rm_lat: got %0d want 9", lat); end
        n_chk++; if (op  !== 1'b1) begin n_fail++; $display("FAIL rm_op2: got %b want 1", op); end
        tick;
    endtask

    task automatic test_back_to_back;
        wvec_t a, b;
        int lat; logic op, b0, o0;
        for (int i = 0; i < WORDS; i++) begin a[i] = 32'h7777_0000 + N'(i); b[i] = a[i]; end
        do_cmp(MODE_EQ, a, b, 1'b0, lat, op, b0, o0);
        n_chk++; if (op !== 1'b1) begin n_fail++; $display("FAIL b2b_op1: got %b want 1", op); end
        b[0] = 32'h7777_0001; b[5] = 32'h0;
        do_cmp(MODE_LT, a, b, 1'b0, lat, op, b0, o0);
        n_chk++; if (b0  !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", b0); end
        n_chk++; if (o0  !== 1'b0) begin n_fail++; $display("FAIL b2b_opclr: got %b want 0", o0); end
        n_chk++; if (lat !== 9)    begin n_fail++; $display("FAIL b2b_lat: got %0d want 9", lat); end
        n_chk++; if (op  !== 1'b1) begin n_fail++; $display("FAIL b2b_op2: got %b want 1", op); end
        tick;
    endtask

    initial begin
        test_reset;
        test_eq;
        test_lt_msw;
        test_equal_modes;
        test_valid_toggle;
        test_restart;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/digest_cmp_seq.md
Name: digest_cmp_seq

Overview:
- Sequential, parametrised successor to the single-word N-bit equality comparator.
- Compares two multi-word values (hash digest vs. target) streamed one word per beat, most-significant word first.
- Supports EQ, NE, unsigned LT and unsigned LE modes.
- Sits after the hash core's digest output: decides digest match or difficulty-target pass, then reports a single-bit verdict with a done pulse.

Parameters:
- N, 32, word width in bits.
- WORDS, 8, words per compared value (default 256-bit digest); must be >= 1.
- CW, $clog2(WORDS+1), beat-counter width (derived, not overridden).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  synchronous active-low reset.
- Start  input  1  begin a new comparison; latches Mode.
- Mode  input  2  00 EQ, 01 NE, 10 LT (DataIn0 < DataIn1), 11 LE (DataIn0 <= DataIn1); all unsigned.
- Valid  input  1  DataIn0/DataIn1 carry a word this cycle.
- DataIn0  input  N  word of value A (digest).
- DataIn1  input  N  word of value B (target).
- Ready  output  1  block accepts a word this cycle.
- Done  output  1  one-cycle pulse: verdict valid.
- Op  output  1  verdict; held from Done until next Start or reset.
- Busy  output  1  comparison in progress.

Behaviour:
- Reset (Rst_n=0 at a Clk edge): state IDLE, Ready=0, Done=0, Op=0, Busy=0, beat count=0, decided/eq/lt flags cleared. Reset mid-comparison aborts it; no Done is produced.
- States:
  - IDLE: Start=1 -> RUN; latch Mode, clear count, set eq_acc=1, decided=0, lt_acc=0.
  - RUN: Ready=1, Busy=1. Each beat with Valid=1 is accepted and the count increments.
  - FIN: one cycle. Done=1, Op updated, Busy=0, Ready=0; next state IDLE.
- Per accepted beat, while decided=0:
  - DataIn0 == DataIn1: eq_acc stays set.
  - Otherwise: eq_acc=0, decided=1, lt_acc=(DataIn0 < DataIn1).
  - Once decided=1, later words are still consumed but do not change the flags (first differing MSW decides).
- The beat bringing the count to WORDS moves RUN -> FIN on the next edge. Total latency = WORDS accepted beats + 1 cycle to Done; with Valid held high, Done asserts WORDS+1 cycles after the Start cycle.
- Verdict in FIN:
  - EQ: eq_acc.
  - NE: ~eq_acc.
  - LT: lt_acc & ~eq_acc.
  - LE: lt_acc | eq_acc.
- Op updates only in FIN and holds its value through IDLE. It clears to 0 on reset or on the cycle a new Start is accepted.
- Valid with Ready=0 (IDLE or FIN): word is ignored, no error.
- Start in RUN: aborts the current comparison and restarts, with Mode re-latched, count cleared and no Done for the aborted one. If Valid=1 in that same cycle, the word belongs to the new comparison and counts as its beat 0.
- Start in FIN: Done still pulses for the finishing comparison; Start is taken and the next state is RUN.
- Mode changes while in RUN have no effect.
- WORDS=1 degenerates to a registered single-word compare with latency 2.
- Count wraps are impossible: FIN is entered exactly at WORDS.

Decomposition:
- Shared package digest_cmp_pkg holds:
  - mode encodings MODE_EQ=2'b00, MODE_NE=2'b01, MODE_LT=2'b10, MODE_LE=2'b11;
  - state encoding IDLE/RUN/FIN.
- One natural combinational sub-module, cmp_word: N-bit word compare producing eq and lt; the existing N-bit comparator's eq function is generalised here.
- FSM, counter and flag accumulation live in digest_cmp_seq.

Test Plan:
- EQ, WORDS=8, N=32, identical words 0x00000000..0x00000007 with Valid held high -> Done at cycle 9 after Start, Op=1; repeat with word 7 differing -> Op=0.
- LT, A word0=0x00000001 and B word0=0x00000002, all other words A=0xFFFFFFFF and B=0x00000000 -> Op=1 (MSW decides; later words ignored).
- LE with all words equal -> Op=1; LT with the same data -> Op=0; NE with the same data -> Op=0.
- Valid toggling 1,0,1,0 in RUN -> exactly 8 accepted beats, Done only after the 8th, Op correct; Valid pulses in IDLE change nothing.
- Start reasserted after 3 beats in RUN -> no Done for the first comparison; the second comparison completes after 8 fresh beats with the newly latched Mode.
- Rst_n=0 for one cycle mid-RUN -> Busy=0, Op=0, no Done; a subsequent Start/8 beats produces a correct verdict.
